// File: rtl/bg_bank_sram_ctrl_pkg.sv
// Shared definitions for the bank-group SRAM controller: default widths,
// bus widths, field offsets of the request/response buses and FSM encoding.
// Optional feature macro used by the controller: BG_DROP_CNT_EN.
package bg_bank_sram_ctrl_pkg;

  localparam int BG_A_W = 10;
  localparam int BG_D_W = 32;

  // Default bus widths.
  localparam int L_C_W = 2 + BG_A_W + BG_D_W;
  localparam int C_L_W = 1 + BG_D_W;

  // Field offsets for the default widths.
  localparam int WEN_BIT    = 1 + BG_A_W + BG_D_W;
  localparam int REN_BIT    = BG_A_W + BG_D_W;
  localparam int ADDR_LSB   = BG_D_W;
  localparam int DATA_LSB   = 0;
  localparam int RVALID_BIT = BG_D_W;

  // Controller state: zero-init sweep, then serving requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bg_state_e;

  // Field offsets for arbitrary widths.
  function automatic int bg_l_c_w(input int a_w, input int d_w);
    return 2 + a_w + d_w;
  endfunction

  function automatic int bg_c_l_w(input int d_w);
    return 1 + d_w;
  endfunction

  function automatic int bg_wen_bit(input int a_w, input int d_w);
    return 1 + a_w + d_w;
  endfunction

  function automatic int bg_ren_bit(input int a_w, input int d_w);
    return a_w + d_w;
  endfunction

endpackage

// File: rtl/bg_sram_1rw.sv
// Behavioural single-port synchronous SRAM, one-cycle read latency.
// A write cycle leaves rdata unchanged; the controller gates rdata anyway.
module bg_sram_1rw #(
  parameter int A_W = 10,
  parameter int D_W = 32
) (
  input  logic           clk,
  input  logic           we,
  input  logic [A_W-1:0] addr,
  input  logic [D_W-1:0] wdata,
  output logic [D_W-1:0] rdata
);

  logic [D_W-1:0] mem [0:(1<<A_W)-1];
  logic [D_W-1:0] rdata_r;

  // Single port: either write the addressed word or read it into rdata_r.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata_r <= mem[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/bg_bank_sram_ctrl.sv
// Bank-group SRAM controller: zero-init sweep after reset, then one SRAM
// access per cycle decoded from the crossbar request bus, with read data
// returned on the response bus RD_LAT cycles later (RD_LAT = 1 or 2).
// Optional macro BG_DROP_CNT_EN adds a saturating dropped-write counter.
module bg_bank_sram_ctrl
  import bg_bank_sram_ctrl_pkg::*;
#(
  parameter int A_W    = BG_A_W,
  parameter int D_W    = BG_D_W,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2+A_W+D_W-1:0]   BG_in,
  output logic [1+D_W-1:0]       R_reponse,
  output logic                   init_done
`ifdef BG_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int WEN_B  = bg_wen_bit(A_W, D_W);
  localparam int REN_B  = bg_ren_bit(A_W, D_W);
  localparam int RESP_W = bg_c_l_w(D_W);
  localparam logic [A_W-1:0] ADDR_MAX = {A_W{1'b1}};
  localparam logic [A_W-1:0] ADDR_ONE = {{(A_W-1){1'b0}}, 1'b1};

  logic           req_wen;
  logic           req_ren;
  logic [A_W-1:0] req_addr;
  logic [D_W-1:0] req_data;

  bg_state_e      state;
  bg_state_e      next_state;
  logic [A_W-1:0] sweep_addr;
  logic           init_done_r;

  logic           mem_we;
  logic [A_W-1:0] mem_addr;
  logic [D_W-1:0] mem_wdata;
  logic [D_W-1:0] mem_rdata;
  logic           rd_fire;

  logic              rvalid1;
  logic [RESP_W-1:0] resp1;

  assign req_wen  = BG_in[WEN_B];
  assign req_ren  = BG_in[REN_B];
  assign req_addr = BG_in[D_W +: A_W];
  assign req_data = BG_in[0 +: D_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next state: leave the sweep once the last address is written.
  always_comb begin
    next_state = state;
    case (state)
      INIT: begin
        if (sweep_addr == ADDR_MAX) begin
          next_state = RUN;
        end else begin
          next_state = INIT;
        end
      end
      RUN:     next_state = RUN;
      default: next_state = INIT;
    endcase
  end

  // Outputs of the FSM: SRAM port control; requests are ignored during the sweep.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = req_addr;
    mem_wdata = req_data;
    rd_fire   = 1'b0;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = sweep_addr;
        mem_wdata = {D_W{1'b0}};
      end
      RUN: begin
        // A read owns the address, so a simultaneous write is dropped.
        rd_fire = req_ren;
        mem_we  = req_wen & ~req_ren;
      end
      default: begin
        mem_we  = 1'b0;
        rd_fire = 1'b0;
      end
    endcase
  end

  // Sweep address walks the bank; init_done rises on the final sweep write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_addr  <= {A_W{1'b0}};
      init_done_r <= 1'b0;
    end else if (state == INIT) begin
      sweep_addr  <= sweep_addr + ADDR_ONE;
      init_done_r <= (next_state == RUN);
    end else begin
      sweep_addr  <= sweep_addr;
      init_done_r <= init_done_r;
    end
  end

  assign init_done = init_done_r;

  bg_sram_1rw #(
    .A_W (A_W),
    .D_W (D_W)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Read-valid tracks the SRAM read stage; cleared at once by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid1 <= 1'b0;
    end else begin
      rvalid1 <= rd_fire;
    end
  end

  // Data is forced to zero when not valid because responses are OR-combined downstream.
  assign resp1 = {rvalid1, (rvalid1 ? mem_rdata : {D_W{1'b0}})};

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [RESP_W-1:0] resp2;

      // Extra output stage for the two-cycle latency build.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          resp2 <= {RESP_W{1'b0}};
        end else begin
          resp2 <= resp1;
        end
      end

      assign R_reponse = resp2;
    end else begin : g_lat1
      assign R_reponse = resp1;
    end
  endgenerate

`ifdef BG_DROP_CNT_EN
  logic        drop_fire;
  logic [15:0] drop_r;

  assign drop_fire = (state == RUN) & req_ren & req_wen;

  // Saturating count of writes lost to a simultaneous read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_r <= 16'h0000;
    end else if (drop_fire && (drop_r != 16'hFFFF)) begin
      drop_r <= drop_r + 16'h0001;
    end else begin
      drop_r <= drop_r;
    end
  end

  assign drop_cnt = drop_r;
`endif

endmodule
